// File: rtl/regbank_scan.sv
// Register bank with a one-cycle registered read port and an auto-scan sequencer
// that streams every entry through the same valid/ready output register.
module regbank_scan #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_ready,
  input  logic             scan_start,
  output logic             busy,
  output logic             scan_done,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [0:0]       state, state_n;
  logic [AW-1:0]    ptr, ptr_n;
  logic [WIDTH-1:0] dout_n;
  logic             valid_n;
  logic             busy_n;
  logic             done_n;
  logic             slot_free;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] scan_word;

  assign slot_free = !out_valid || out_ready;
  assign rd_ready  = (state == IDLE) && slot_free && !scan_start;

  // Write-first: a same-cycle write to the addressed entry is seen by the load.
  always_comb begin
    rd_word   = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    scan_word = (wr_en && (wr_addr == ptr))     ? wr_data : mem[ptr];
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    dout_n  = dout;
    valid_n = out_valid;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (scan_start) begin
          state_n = SCAN;
          ptr_n   = '0;
          busy_n  = 1'b1;
          // A word consumed on the start cycle must not be presented again.
          if (out_ready) valid_n = 1'b0;
        end else if (rd_en && rd_ready) begin
          dout_n  = rd_word;
          valid_n = 1'b1;
        end else if (out_ready) begin
          valid_n = 1'b0;
        end
      end
      SCAN: begin
        if (slot_free) begin
          dout_n  = scan_word;
          valid_n = 1'b1;
          ptr_n   = ptr + AW'(1);
          if (ptr == LAST_ADDR) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      dout      <= dout_n;
      out_valid <= valid_n;
      busy      <= busy_n;
      scan_done <= done_n;
    end
  end

endmodule

// File: tb/tb_regbank_scan.sv
// Directed bench for regbank_scan: a transaction-level model checked every cycle
// plus literal expectations from the hand-worked scenarios.
module tb_regbank_scan;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic [AW-1:0]    rd_addr = '0;
  logic             rd_ready;
  logic             scan_start = 1'b0;
  logic             busy;
  logic             scan_done;
  logic [WIDTH-1:0] dout;
  logic             out_valid;
  logic             out_ready = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  regbank_scan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .scan_start(scan_start), .busy(busy), .scan_done(scan_done),
    .dout(dout), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: bank contents, the output word, and a queue of addresses a scan still owes.
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic [WIDTH-1:0] m_dout;
  logic             m_valid;
  logic             m_done;
  bit               m_known = 1'b0;
  int               m_pending[$];
  bit               recording = 1'b0;
  logic [WIDTH-1:0] delivered[$];

  function automatic logic [WIDTH-1:0] m_entry(input int a);
    if (wr_en && (int'(wr_addr) == a)) return wr_data;
    return m_mem[a];
  endfunction

  always @(negedge clk) begin
    if (m_known) begin
      check("model dout",      32'(dout),      32'(m_dout));
      check("model out_valid", 32'(out_valid), 32'(m_valid));
      check("model busy",      32'(busy),      32'(m_pending.size() != 0));
      check("model scan_done", 32'(scan_done), 32'(m_done));
      check("model rd_ready",  32'(rd_ready),
            32'(m_pending.size() == 0 && (!m_valid || out_ready) && !scan_start));
    end
    if (recording && out_valid && out_ready) delivered.push_back(dout);

    if (reset) begin
      m_known = 1'b1;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_dout  = '0;
      m_valid = 1'b0;
      m_done  = 1'b0;
      m_pending.delete();
    end else begin
      bit free;
      free   = !m_valid || out_ready;
      m_done = 1'b0;
      if (m_pending.size() == 0) begin
        if (scan_start) begin
          for (int i = 0; i < DEPTH; i++) m_pending.push_back(i);
          if (out_ready) m_valid = 1'b0;
        end else if (rd_en && free) begin
          m_dout  = m_entry(int'(rd_addr));
          m_valid = 1'b1;
        end else if (out_ready) begin
          m_valid = 1'b0;
        end
      end else if (free) begin
        m_dout  = m_entry(m_pending.pop_front());
        m_valid = 1'b1;
        if (m_pending.size() == 0) m_done = 1'b1;
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
    end
  end

  // Inputs change 2 time units after each rising edge; strobes last one cycle.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                               input logic re, input logic [AW-1:0] ra,
                               input logic ss, input logic ordy);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra;
    scan_start = ss; out_ready = ordy;
    @(posedge clk); #2;
    wr_en = 1'b0; rd_en = 1'b0; scan_start = 1'b0;
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, ordy);
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] exp_dout,
                             input logic exp_valid, input logic exp_busy, input logic exp_done);
    check({name, " dout"},      32'(dout),      32'(exp_dout));
    check({name, " out_valid"}, 32'(out_valid), 32'(exp_valid));
    check({name, " busy"},      32'(busy),      32'(exp_busy));
    check({name, " scan_done"}, 32'(scan_done), 32'(exp_done));
  endtask

  logic [WIDTH-1:0] scan_words [DEPTH];

  initial begin
    scan_words = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset then a read of an empty entry.
    doReset(2);
    checkOutput("t1 reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("t1 rd_ready", 32'(rd_ready), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd2, 1'b0, 1'b1);
    checkOutput("t1 read", 8'h00, 1'b1, 1'b0, 1'b0);

    // Fill the bank and read one entry back.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, AW'(i), scan_words[i], 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd2, 1'b0, 1'b1);
    checkOutput("t2 read", 8'h33, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    checkOutput("t2 drain", 8'h33, 1'b0, 1'b0, 1'b0);

    // Same-cycle write and read of one address.
    applyStimulus(1'b1, 2'd1, 8'hA5, 1'b1, 2'd1, 1'b0, 1'b1);
    checkOutput("t3 bypass", 8'hA5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd1, 1'b0, 1'b1);
    checkOutput("t3 stored", 8'hA5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd1, 8'h22, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("t3 restore", 8'hA5, 1'b0, 1'b0, 1'b0);

    // Unstalled scan.
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("t4 start", 8'hA5, 1'b0, 1'b1, 1'b0);
    check("t4 rd_ready start", 32'(rd_ready), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      idle(1'b1);
      checkOutput($sformatf("t4 word%0d", i), scan_words[i], 1'b1, i < DEPTH - 1, i == DEPTH - 1);
      if (i < DEPTH - 1) check($sformatf("t4 rd_ready%0d", i), 32'(rd_ready), 32'd0);
    end
    idle(1'b1);
    checkOutput("t4 after", 8'h44, 1'b0, 1'b0, 1'b0);

    // Scan stalled by the consumer after the first word.
    recording = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    idle(1'b1);
    checkOutput("t5 first", 8'h11, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      checkOutput($sformatf("t5 hold%0d", i), 8'h11, 1'b1, 1'b1, 1'b0);
    end
    for (int i = 1; i < DEPTH; i++) begin
      idle(1'b1);
      checkOutput($sformatf("t5 word%0d", i), scan_words[i], 1'b1, i < DEPTH - 1, i == DEPTH - 1);
    end
    idle(1'b1);
    recording = 1'b0;
    check("t5 words delivered", 32'(delivered.size()), 32'(DEPTH));
    for (int i = 0; i < delivered.size() && i < DEPTH; i++)
      check($sformatf("t5 delivered%0d", i), 32'(delivered[i]), 32'(scan_words[i]));

    // Reset aborts a scan and clears the bank.
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    checkOutput("t6 second", 8'h22, 1'b1, 1'b1, 1'b0);
    doReset(1);
    checkOutput("t6 reset", 8'h00, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    checkOutput("t6 no done", 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      idle(1'b1);
      checkOutput($sformatf("t6 word%0d", i), 8'h00, 1'b1, i < DEPTH - 1, i == DEPTH - 1);
    end
    idle(1'b1);
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regbank_scan.md
Name: regbank_scan

Overview:
- Parametrised register bank: DEPTH entries of WIDTH bits, one synchronous write port, one registered read port with valid/ready output handshake.
- Includes an auto-scan sequencer that streams every entry, 0 to DEPTH-1, through the same output register.
- Generalises the fixed two-register/mux/output-register datapath into a reusable storage and readout block for the microprocessor datapath.
- Typical uses: register-file dumps and operand staging.

Parameters:
- WIDTH, 8, data width of each entry and of dout.
- DEPTH, 4, number of entries; power of two, at least 2.
- AW, $clog2(DEPTH), address width; derived localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  single-read request.
- rd_addr  in  AW  single-read address.
- rd_ready  out  1  combinational; high when a single read is accepted this cycle.
- scan_start  in  1  request a full-bank scan.
- busy  out  1  registered; high while in SCAN.
- scan_done  out  1  registered; one-cycle pulse, the cycle after the last scan entry is loaded.
- dout  out  WIDTH  registered output data.
- out_valid  out  1  registered; dout holds an unconsumed word.
- out_ready  in  1  consumer accepts dout when out_valid and out_ready are both high.

Behaviour:
- Reset (synchronous, reset=1 at posedge):
  - all entries, dout, out_valid, busy, scan_done and the scan pointer go to 0; state goes to IDLE.
  - reset has priority over every other input, including mid-scan; a scan in progress is aborted and no scan_done is issued.
- Write: when wr_en=1, mem[wr_addr] <= wr_data at posedge. Writes are accepted in every state, with no backpressure.
- slot_free = !out_valid || out_ready. This is the output register's load condition.
- State IDLE:
  - rd_ready = slot_free && !scan_start.
  - If scan_start=1: go to SCAN, ptr <= 0, busy <= 1. A simultaneous rd_en is dropped, since scan has priority.
  - Else if rd_en && rd_ready: dout <= entry(rd_addr), out_valid <= 1; latency is 1 cycle.
  - Else if out_ready: out_valid <= 0.
- State SCAN:
  - rd_ready = 0. rd_en and scan_start are ignored.
  - Each cycle with slot_free: dout <= entry(ptr), out_valid <= 1, ptr <= ptr+1.
  - If slot is not free, ptr and dout hold.
  - On loading ptr = DEPTH-1: return to IDLE, busy <= 0, scan_done <= 1 for exactly one cycle, ptr wraps to 0.
- Write-first bypass: entry(a) = wr_data when wr_en && wr_addr==a in the same cycle; otherwise mem[a]. This applies to both single reads and scan loads.
- Back-to-back: with out_ready held at 1, a scan emits DEPTH words on consecutive cycles, and single reads issue one per cycle.
- Output stability: while out_valid=1 and out_ready=0, dout and out_valid are unchanged.
- Total scan duration with no stalls: DEPTH+1 cycles from scan_start to the scan_done pulse.

Test Plan:
1. Reset then idle (WIDTH=8, DEPTH=4): after reset, out_valid=0, dout=0x00, busy=0, rd_ready=1; single read of addr 2 -> next cycle dout=0x00, out_valid=1.
2. Write/read: write 0x11,0x22,0x33,0x44 to addr 0..3; rd_en addr 2 with out_ready=1 -> next cycle dout=0x33, out_valid=1; next cycle with no rd_en -> out_valid=0.
3. Bypass: wr_en addr 1 data 0xA5 and rd_en addr 1 in the same cycle -> dout=0xA5 next cycle; mem[1] reads 0xA5 afterwards.
4. Full scan, out_ready=1: scan_start pulse -> dout 0x11,0x22,0x33,0x44 on 4 consecutive cycles; busy high for 4 cycles; scan_done pulses once, coincident with dout=0x44; rd_ready=0 throughout.
5. Backpressure: scan with out_ready=0 for 3 cycles after the first word -> dout held at 0x11 with out_valid=1; resumes 0x22 after out_ready=1; exactly 4 words delivered, none duplicated.
6. Reset mid-scan: assert reset after the second word -> next cycle busy=0, out_valid=0, all entries 0x00, no scan_done; a new scan then returns four 0x00 words.
